// File: rtl/conv_output_pool_pkg.sv
// Shared types and default configuration for the conv output/pool stage.
// Provides the frame FSM state enum, the 2x2 window role enum and the
// parity-to-role helper, plus default config values and coordinate widths.
package conv_output_pool_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_FMAP_WIDTH   = 128;
  localparam int DEF_FMAP_HEIGHT  = 128;
  localparam int DEF_NB_CHANNELS  = 32;

  localparam int X_W  = $clog2(DEF_FMAP_WIDTH);
  localparam int Y_W  = $clog2(DEF_FMAP_HEIGHT);
  localparam int CH_W = $clog2(DEF_NB_CHANNELS);

  typedef enum logic {
    IDLE,
    ACTIVE
  } pool_state_e;

  // Role of a sample inside its 2x2 window: first (top-left) sample seeds
  // the entry, the two middle samples fold in, the bottom-right one emits.
  typedef enum logic [1:0] {
    P_INIT,
    P_UPD,
    P_EMIT
  } pool_role_e;

  function automatic pool_role_e role_of(input logic y0, input logic x0);
    case ({y0, x0})
      2'b00:   return P_INIT;
      2'b11:   return P_EMIT;
      default: return P_UPD;
    endcase
  endfunction

endpackage

// File: rtl/pool_window_buf.sv
// Partial-max storage for 2x2 pooling: one data entry plus one valid bit per
// (pooled x, channel). Combinational read, clocked write, synchronous
// clear of every valid bit.
//   clk      clock
//   clr_all  clear all valid bits (wins over a write in the same cycle)
//   rd_addr  read address; rd_data/rd_valid follow combinationally
//   wr_en    write wr_data/wr_valid to wr_addr at the clock edge
module pool_window_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ENTRIES    = 2048,
  parameter int ADDR_W     = $clog2(ENTRIES)
) (
  input  logic                         clk,
  input  logic                         clr_all,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         wr_valid
);

  logic signed [DATA_WIDTH-1:0] mem [ENTRIES];
  logic [ENTRIES-1:0]           vld;

  assign rd_data  = mem[rd_addr];
  assign rd_valid = vld[rd_addr];

  // NOTE: the data array has no reset; its contents are only trusted when
  // the matching valid bit is set, so clearing the valid bits is enough.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (clr_all)    vld          <= '0;
    else if (wr_en) vld[wr_addr] <= wr_valid;
  end

endmodule

// File: rtl/conv_output_pool.sv
// Output stage of the convolution core: optional ReLU, then optional 2x2
// stride-2 max-pooling, producing a coordinate-tagged stream. Counts emitted
// outputs against a per-frame target and pulses done on the last one.
//   clk, rst                 clock, synchronous active-high reset
//   start                    frame start; latches relu_en/pool_en/expected_count
//   in_*                     conv result stream, one sample per cycle, no stall
//   out_*                    result stream, out_valid is a one-cycle qualifier
//   running                  frame in progress
//   done                     one-cycle pulse with the final output of the frame
//   order_err                sticky: a window was visited out of order
module conv_output_pool
  import conv_output_pool_pkg::*;
#(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int FEATURE_MAP_WIDTH  = DEF_FMAP_WIDTH,
  parameter int FEATURE_MAP_HEIGHT = DEF_FMAP_HEIGHT,
  parameter int OUTPUT_NB_CHANNELS = DEF_NB_CHANNELS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   relu_en,
  input  logic                                   pool_en,
  input  logic [31:0]                            expected_count,
  input  logic signed [DATA_WIDTH-1:0]           in_data,
  input  logic                                   in_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]   in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]  in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]  in_ch,
  output logic signed [DATA_WIDTH-1:0]           out_data,
  output logic                                   out_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]   out_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]  out_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]  out_ch,
  output logic                                   running,
  output logic                                   done,
  output logic                                   order_err
);

  localparam int XW          = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW          = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW          = $clog2(OUTPUT_NB_CHANNELS);
  localparam int BUF_ENTRIES = (FEATURE_MAP_WIDTH / 2) * OUTPUT_NB_CHANNELS;
  localparam int BUF_AW      = (XW - 1) + CW;

  pool_state_e state, state_nxt;
  logic        relu_q, pool_q;
  logic [31:0] exp_q, emit_cnt;
  logic        done_nxt;

  logic                         accept;
  logic signed [DATA_WIDTH-1:0] v, mx;
  pool_role_e                   role;
  logic [BUF_AW-1:0]            buf_addr;
  logic signed [DATA_WIDTH-1:0] buf_rd_data;
  logic                         buf_rd_valid;
  logic                         buf_wr_en, buf_wr_valid;
  logic signed [DATA_WIDTH-1:0] buf_wr_data;

  logic                         emit, err_hit;
  logic signed [DATA_WIDTH-1:0] emit_data;
  logic [XW-1:0]                emit_x;
  logic [YW-1:0]                emit_y;
  logic [CW-1:0]                emit_ch;

  // Window entry address: pooled column and channel.
  assign buf_addr = {in_x[XW-1:1], in_ch};
  assign running  = (state == ACTIVE);

  pool_window_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (BUF_ENTRIES),
    .ADDR_W     (BUF_AW)
  ) u_window_buf (
    .clk      (clk),
    .clr_all  (rst | start),
    .rd_addr  (buf_addr),
    .rd_data  (buf_rd_data),
    .rd_valid (buf_rd_valid),
    .wr_en    (buf_wr_en),
    .wr_addr  (buf_addr),
    .wr_data  (buf_wr_data),
    .wr_valid (buf_wr_valid)
  );

  // NOTE: every signal driven here gets a default first so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    accept       = (state == ACTIVE) && in_valid && !start;
    v            = (relu_q && in_data[DATA_WIDTH-1]) ? '0 : in_data;
    mx           = (buf_rd_data > v) ? buf_rd_data : v;
    role         = role_of(in_y[0], in_x[0]);
    buf_wr_en    = 1'b0;
    buf_wr_valid = 1'b0;
    buf_wr_data  = v;
    emit         = 1'b0;
    err_hit      = 1'b0;
    emit_data    = v;
    emit_x       = in_x;
    emit_y       = in_y;
    emit_ch      = in_ch;

    if (accept) begin
      if (!pool_q) begin
        emit = 1'b1;
      end else begin
        buf_wr_en = 1'b1;
        emit_x    = in_x >> 1;
        emit_y    = in_y >> 1;
        unique case (role)
          P_INIT: begin
            buf_wr_valid = 1'b1;
            err_hit      = buf_rd_valid;
          end
          P_UPD: begin
            buf_wr_valid = 1'b1;
            buf_wr_data  = buf_rd_valid ? mx : v;
            err_hit      = !buf_rd_valid;
          end
          default: begin
            emit      = 1'b1;
            emit_data = buf_rd_valid ? mx : v;
            err_hit   = !buf_rd_valid;
          end
        endcase
      end
    end

    state_nxt = state;
    done_nxt  = 1'b0;
    if (start) begin
      // An empty frame completes immediately without entering ACTIVE.
      state_nxt = (expected_count == 32'd0) ? IDLE : ACTIVE;
      done_nxt  = (expected_count == 32'd0);
    end else if (emit && (emit_cnt + 32'd1 == exp_q)) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      relu_q    <= 1'b0;
      pool_q    <= 1'b0;
      exp_q     <= '0;
      emit_cnt  <= '0;
      done      <= 1'b0;
      order_err <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_ch    <= '0;
    end else begin
      state     <= state_nxt;
      done      <= done_nxt;
      out_valid <= emit;
      if (emit) begin
        out_data <= emit_data;
        out_x    <= emit_x;
        out_y    <= emit_y;
        out_ch   <= emit_ch;
      end
      if (start) begin
        relu_q    <= relu_en;
        pool_q    <= pool_en;
        exp_q     <= expected_count;
        emit_cnt  <= '0;
        order_err <= 1'b0;
      end else begin
        if (emit && emit_cnt != '1) emit_cnt <= emit_cnt + 32'd1;
        if (err_hit) order_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_output_pool.sv
module tb_conv_output_pool;
  import conv_output_pool_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, start, relu_en, pool_en, in_valid;
  logic [31:0]             expected_count;
  logic signed [15:0]      in_data;
  logic [X_W-1:0]          in_x;
  logic [Y_W-1:0]          in_y;
  logic [CH_W-1:0]         in_ch;
  logic signed [15:0]      out_data;
  logic                    out_valid, running, done, order_err;
  logic [X_W-1:0]          out_x;
  logic [Y_W-1:0]          out_y;
  logic [CH_W-1:0]         out_ch;

  typedef struct {
    int data; int x; int y; int ch; int done; int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   lone_done_ok = 1'b0;

  conv_output_pool dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .pool_en(pool_en),
    .expected_count(expected_count), .in_data(in_data), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .out_data(out_data),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .running(running), .done(done), .order_err(order_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int x, input int y, input int ch, input int dn);
    exp_t e;
    e.data = d; e.x = x; e.y = y; e.ch = ch; e.done = dn; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic send(input int d, input int x, input int y, input int ch);
    in_data  = 16'(d);
    in_x     = X_W'(x);
    in_y     = Y_W'(y);
    in_ch    = CH_W'(ch);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_frame(input bit relu, input bit pool, input int cnt);
    relu_en        = relu;
    pool_en        = pool;
    expected_count = 32'(cnt);
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  // Monitor: every out_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got data=%0d x=%0d y=%0d ch=%0d, expected none",
                 out_data, out_x, out_y, out_ch);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_x", out_x, e.x);
        check("out_y", out_y, e.y);
        check("out_ch", out_ch, e.ch);
        check("out_done", done, e.done);
        check("out_latency_cycle", cyc, e.cyc);
      end
    end else if (done) begin
      check("lone_done_allowed", lone_done_ok, 1);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; pool_en = 1'b0; in_valid = 1'b0;
    expected_count = '0; in_data = '0; in_x = '0; in_y = '0; in_ch = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_order_err", order_err, 0);
    check("rst_out_x", out_x, 0);

    // 1: pass-through
    start_frame(0, 0, 4);
    check("t1_running", running, 1);
    push(-5, 0, 0, 0, 0); send(-5, 0, 0, 0);
    push( 3, 1, 0, 0, 0); send( 3, 1, 0, 0);
    push( 0, 0, 1, 0, 0); send( 0, 0, 1, 0);
    push( 7, 1, 1, 0, 1); send( 7, 1, 1, 0);
    check("t1_running_drops", running, 0);

    // IDLE input must be ignored
    send(99, 1, 1, 0);
    tick();

    // 2: ReLU only
    start_frame(1, 0, 4);
    push(0, 0, 0, 0, 0); send(-5, 0, 0, 0);
    push(3, 1, 0, 0, 0); send( 3, 1, 0, 0);
    push(0, 0, 1, 0, 0); send(-1, 0, 1, 0);
    push(7, 1, 1, 0, 1); send( 7, 1, 1, 0);

    // 3: 2x2 pool, channels interleaved in raster order
    start_frame(0, 1, 2);
    send( 1, 0, 0, 0); send(-8, 0, 0, 1);
    send( 9, 1, 0, 0); send(-3, 1, 0, 1);
    send( 4, 0, 1, 0); send(-6, 0, 1, 1);
    push( 9, 0, 0, 0, 0); send( 2, 1, 1, 0);
    push(-3, 0, 0, 1, 1); send(-7, 1, 1, 1);
    check("t3_order_err", order_err, 0);
    check("t3_running_drops", running, 0);

    // 4: pool plus ReLU, window at pooled (1,1)
    start_frame(1, 1, 1);
    send(-4, 2, 2, 0); send(-2, 3, 2, 0); send(-9, 2, 3, 0);
    push(0, 1, 1, 0, 1); send(-1, 3, 3, 0);

    // 5: order error, emit sample arrives first
    start_frame(0, 1, 1);
    push(5, 0, 0, 0, 1); send(5, 1, 1, 0);
    check("t5_order_err_set", order_err, 1);
    tick(); tick(); tick();
    check("t5_order_err_sticky", order_err, 1);

    // 6: abort mid-window, then a clean frame
    start_frame(0, 1, 4);
    check("t6_order_err_cleared", order_err, 0);
    send(7, 0, 0, 0); send(8, 1, 0, 0); send(9, 0, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_running_after_rst", running, 0);
    check("t6_done_after_rst", done, 0);
    start_frame(0, 1, 1);
    send(1, 0, 0, 0); send(2, 1, 0, 0); send(3, 0, 1, 0);
    push(4, 0, 0, 0, 1); send(4, 1, 1, 0);
    check("t6_order_err", order_err, 0);

    // 7: empty frame completes the cycle after start
    lone_done_ok = 1'b1;
    start_frame(0, 0, 0);
    check("t7_done_pulse", done, 1);
    check("t7_running", running, 0);
    tick();
    lone_done_ok = 1'b0;
    check("t7_done_clears", done, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_output_pool.md
Name: conv_output_pool

Overview:
- Downstream stage of the convolution core. Consumes the core's output stream: output_data plus output_x/output_y/output_ch, qualified by output_valid. There is no backpressure.
- Applies optional ReLU, then optional 2x2 stride-2 max-pooling.
- Emits a pooled, coordinate-tagged stream to the output writer.
- Tracks frame completion against a programmed output count.

Parameters:
- DATA_WIDTH, 16, signed sample width.
- FEATURE_MAP_WIDTH, 128, max conv output width (x range).
- FEATURE_MAP_HEIGHT, 128, max conv output height (y range).
- OUTPUT_NB_CHANNELS, 32, number of output channels (ch range).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  frame start pulse; latches the mode inputs.
- relu_en  in  1  apply ReLU (sampled at start).
- pool_en  in  1  apply 2x2 max-pool; 0 = pass-through (sampled at start).
- expected_count  in  32  number of outputs this frame (sampled at start).
- in_data  in  DATA_WIDTH  signed conv result.
- in_valid  in  1  in_data/coords valid; must be accepted every cycle.
- in_x  in  $clog2(FEATURE_MAP_WIDTH)  x coordinate.
- in_y  in  $clog2(FEATURE_MAP_HEIGHT)  y coordinate.
- in_ch  in  $clog2(OUTPUT_NB_CHANNELS)  channel.
- out_data  out  DATA_WIDTH  signed result.
- out_valid  out  1  one-cycle qualifier; no ready.
- out_x  out  $clog2(FEATURE_MAP_WIDTH)  pooled x (in_x>>1 when pooling).
- out_y  out  $clog2(FEATURE_MAP_HEIGHT)  pooled y.
- out_ch  out  $clog2(OUTPUT_NB_CHANNELS)  channel.
- running  out  1  high in state ACTIVE.
- done  out  1  one-cycle pulse at frame end.
- order_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, all window valid bits 0.
- rst mid-frame aborts the frame; no done pulse is issued.
- FSM IDLE -> ACTIVE on start:
  - Latches relu_en, pool_en and expected_count.
  - Clears emit_cnt, order_err and all valid bits.
- FSM ACTIVE -> IDLE in the same cycle the emit that makes emit_cnt == expected_count registers.
  - done pulses together with that out_valid.
  - expected_count == 0: done pulses the cycle after start, return to IDLE.
- start while ACTIVE restarts the frame exactly as from IDLE; in-flight window state is discarded.
- in_valid in IDLE: ignored, no output.
- Data path, per accepted sample:
  - v = relu_en ? (in_data < 0 ? 0 : in_data) : in_data. Signed compare throughout.
- pool_en = 0:
  - Register v and its coords.
  - out_valid the next cycle (latency 1).
- pool_en = 1, window buffer:
  - One entry of DATA_WIDTH plus one valid bit per (in_x>>1, in_ch), i.e. FEATURE_MAP_WIDTH/2 * OUTPUT_NB_CHANNELS entries.
  - Combinational read, write on clk edge. Back-to-back hits on the same entry therefore need no forwarding.
- Window role is set by parity p = {in_y[0], in_x[0]}:
  - p = 00: entry = v; valid = 1. If valid was already 1, set order_err and overwrite.
  - p = 01 or 10: entry = max(entry, v). If valid = 0, set order_err and store v with valid = 1.
  - p = 11: emit max(entry, v) with coords (in_x>>1, in_y>>1, in_ch) one cycle later; clear valid. If valid = 0, set order_err and emit v.
- Ordering contract:
  - Per window, the p = 00 sample arrives first and the p = 11 sample last.
  - Raster order with any channel interleave satisfies this.
- Odd map sizes: trailing odd row/column samples update the buffer but never emit.
- emit_cnt increments on every out_valid.
  - It saturates; emits beyond expected_count cannot occur because the FSM leaves ACTIVE.
- Throughput: one input per cycle sustained, no stalls.

Decomposition:
- Shared package:
  - pool_state_e {IDLE, ACTIVE}.
  - Parity role enum {P_INIT, P_UPD, P_EMIT}.
  - Coordinate width localparams derived from the config.
- Sub-module pool_window_buf: the entry/valid register array.
  - One read port, one write port, synchronous clear-all.
- FSM, ReLU, compare and output register stay in conv_output_pool.

Test Plan:
1. Pass-through:
   - Stimulus: pool_en = 0, relu_en = 0, expected_count = 4; samples -5, 3, 0, 7 at (0,0,0), (1,0,0), (0,1,0), (1,1,0).
   - Response: the same four values and coords, each 1 cycle later; done with the 4th out_valid; running drops.
2. ReLU only:
   - Stimulus: pool_en = 0, relu_en = 1; samples -5, 3, -1, 7.
   - Response: 0, 3, 0, 7.
3. 2x2 pool, two channels interleaved:
   - Stimulus: raster order, ch inner; ch0 values 1, 9, 4, 2 and ch1 values -8, -3, -6, -7; expected_count = 2.
   - Response: exactly two outputs, (0,0,0) = 9 and (0,0,1) = -3. Both arrive 1 cycle after the p = 11 sample. done fires on the second.
4. Pool plus ReLU:
   - Stimulus: window -4, -2, -9, -1 with relu_en = 1.
   - Response: out_data 0.
5. Order error:
   - Stimulus: send the p = 11 sample of a fresh window first, value 5.
   - Response: order_err = 1 and stays set; out_data 5 emitted; the next start clears order_err.
6. Abort:
   - Stimulus: assert rst after 3 of 4 window samples, then start a new frame and send a full window 1, 2, 3, 4.
   - Response: no done before rst; the new frame emits 4 with no stale data.
